regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Debug reader for the integer register file. On a start pulse it walks architectural registers x0..x(NUM_REGS-1) through one register-file read port.
- Each 32-bit value is serialized into bytes on a valid/ready byte stream that feeds the debug UART transmitter.
- The stream is framed by a sync byte at the front and an XOR checksum at the end.
- Sits beside the core; uses a spare read port, or is muxed onto one while the core is halted.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at index 0; range 2..32.
- SYNC_BYTE, 8'hA5, frame header byte sent first.
- MSB_FIRST, 1, 1 = bits [31:24] sent first; 0 = bits [7:0] sent first.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to begin a dump; honoured only in IDLE.
- abort  input  1  cancels a dump in progress.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the checksum byte is accepted.
- rf_addr  output  5  register-file read address.
- rf_data  input  32  register-file read data, combinational from rf_addr; x0 reads 0.
- tx_valid  output  1  byte available on tx_data.
- tx_ready  input  1  sink accepts the byte when tx_valid and tx_ready are both high on a rising edge.
- tx_data  output  8  byte being offered.

Behaviour:
- Reset values, forced asynchronously while reset=0:
  - state=IDLE, busy=0, done=0, tx_valid=0, tx_data=0.
  - rf_addr=0, internal index=0, byte counter=0, checksum=0, capture register=0.
- rf_addr always equals the internal index. The index is 5 bits and counts 0..NUM_REGS-1; it never wraps past NUM_REGS-1.
- IDLE: start=1 moves to SYNC on the next cycle. That edge also clears the index, byte counter and checksum.
- SYNC:
  - tx_valid=1, tx_data=SYNC_BYTE.
  - On handshake, go to READ.
  - SYNC_BYTE is not included in the checksum.
- READ:
  - Exactly one cycle, tx_valid=0.
  - At the end of the cycle, capture rf_data into the 32-bit capture register, clear the byte counter, go to SEND.
- SEND:
  - tx_valid=1.
  - tx_data is byte k of the captured word, k=0..3, in the order set by MSB_FIRST.
  - On each handshake: checksum ^= tx_data, k increments.
  - On the handshake with k=3: if index==NUM_REGS-1, go to CSUM; otherwise index+1 and go to READ.
- CSUM:
  - tx_valid=1, tx_data=checksum, i.e. the XOR of all 4*NUM_REGS data bytes.
  - On handshake: done=1 for that one cycle, go to IDLE.
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and the state is held.
  - tx_valid never drops without a handshake, except on abort or reset.
- Per-register throughput with tx_ready held high: 5 cycles (1 READ + 4 SEND).
- Full-frame latency from the start edge to done with tx_ready=1: 1 + 5*NUM_REGS + 1 cycles, i.e. 162 cycles for NUM_REGS=32.
- busy=1 from the cycle after start until the cycle after done.
- Simultaneous events:
  - start while busy: ignored.
  - start and abort in the same IDLE cycle: abort wins and the block stays in IDLE.
- abort=1 in any non-IDLE state:
  - The next state is IDLE with tx_valid=0, and done is not pulsed.
  - This is the only permitted withdrawal of a pending byte; the sink must discard a partial frame.
  - The checksum and index are cleared on the next start.
- rf_data is sampled only in READ, so register writes by the core during SEND do not corrupt the byte being sent.
- Reset asserted mid-dump: immediate return to the reset values; no done pulse.

Test Plan:
- Ordering: NUM_REGS=32, MSB_FIRST=1, tx_ready=1, regfile x[i]=32'h01020300+i, start pulse.
  - Expect 130 bytes: A5, then x0 as 00 00 00 00, then x1 as 01 02 03 01, ... x31 as 01 02 03 1F, then the checksum.
  - done pulses exactly at cycle 162 after the start edge; busy drops the following cycle.
- Checksum: all registers 32'hFFFFFFFF except x0=0 → checksum byte 8'h00 (124 bytes of FF XOR to 0). Set x5=32'h00000001 instead → checksum 8'h01.
- Backpressure: tx_ready toggles 1,0,0,1 repeating.
  - tx_data and tx_valid hold steady during every ready=0 cycle.
  - The byte sequence is identical to the ordering test; no byte is dropped or duplicated.
- Byte order: MSB_FIRST=0, x1=32'hDEADBEEF → bytes for x1 are EF BE AD DE.
- Abort and restart:
  - Assert abort during the SEND of x10 byte 2 → next cycle tx_valid=0, busy=0, no done.
  - A new start then produces a full, correct frame beginning with A5 and a correct checksum.
- Reset and ignored start:
  - Pull reset low mid-SEND → all outputs go to reset values without waiting for a clock edge.
  - A start pulse while busy=1 leaves the frame unchanged.

Source files
------------

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | regfile_dump_reader : streams x0..x(NUM_REGS-1) as sync + data + XOR csum   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module regfile_dump_reader #(
  parameter int         NUM_REGS  = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_READ = 3'd2,
    ST_SEND = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] cap_q, cap_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        w_hs;
  logic [7:0]  w_csum_next;

  // Byte k of a word in wire order; lane 3 is bits [31:24].
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - k) : k;
    pick_byte = word[{lane, 3'b000} +: 8];
  endfunction

  assign w_hs        = tx_valid_q && tx_ready;
  assign w_csum_next = csum_q ^ tx_data_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    csum_d     = csum_q;
    cap_d      = cap_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_SYNC;
          idx_d      = 5'd0;
          k_d        = 2'd0;
          csum_d     = 8'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end
      end
      ST_SYNC: begin
        if (w_hs) begin
          state_d    = ST_READ;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'd0;
        end
      end
      ST_READ: begin
        // The only cycle rf_data is sampled; later core writes cannot tear the word.
        cap_d      = rf_data;
        k_d        = 2'd0;
        state_d    = ST_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = pick_byte(rf_data, 2'd0);
      end
      ST_SEND: begin
        if (w_hs) begin
          csum_d = w_csum_next;
          if (k_q == 2'd3) begin
            if (idx_q == LAST_IDX) begin
              state_d   = ST_CSUM;
              tx_data_d = w_csum_next;
            end else begin
              idx_d      = idx_q + 5'd1;
              state_d    = ST_READ;
              tx_valid_d = 1'b0;
              tx_data_d  = 8'd0;
            end
          end else begin
            k_d       = k_q + 2'd1;
            tx_data_d = pick_byte(cap_q, k_q + 2'd1);
          end
        end
      end
      ST_CSUM: begin
        if (w_hs) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'd0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'd0;
      end
    endcase

    // Abort withdraws any pending byte; the sink drops the partial frame.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      k_q        <= 2'd0;
      csum_q     <= 8'd0;
      cap_q      <= 32'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      k_q        <= k_d;
      csum_q     <= csum_d;
      cap_q      <= cap_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // done marks the cycle in which the checksum byte is accepted.
  assign done     = (state_q == ST_CSUM) && tx_ready && !abort;
  assign busy     = (state_q != ST_IDLE);
  assign rf_addr  = idx_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_regfile_dump_reader : directed bench for regfile_dump_reader             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort, tx_ready, dsel;
  logic [31:0] rf [0:31];

  logic        a_busy, a_done, a_valid, b_busy, b_done, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic [31:0] a_rf_data, b_rf_data;
  logic        o_busy, o_done, o_valid;
  logic [4:0]  o_addr;
  logic [7:0]  o_data;
  logic        a_start, a_abort, a_ready, b_start, b_abort, b_ready;

  assign a_rf_data = (a_addr == 5'd0) ? 32'h0 : rf[a_addr];
  assign b_rf_data = (b_addr == 5'd0) ? 32'h0 : rf[b_addr];
  assign a_start = start & ~dsel;
  assign a_abort = abort & ~dsel;
  assign a_ready = dsel ? 1'b1 : tx_ready;
  assign b_start = start & dsel;
  assign b_abort = abort & dsel;
  assign b_ready = dsel ? tx_ready : 1'b1;
  assign o_busy  = dsel ? b_busy  : a_busy;
  assign o_done  = dsel ? b_done  : a_done;
  assign o_valid = dsel ? b_valid : a_valid;
  assign o_addr  = dsel ? b_addr  : a_addr;
  assign o_data  = dsel ? b_data  : a_data;

  regfile_dump_reader #(.NUM_REGS(32), .SYNC_BYTE(8'hA5), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .rf_addr(a_addr), .rf_data(a_rf_data),
    .tx_valid(a_valid), .tx_ready(a_ready), .tx_data(a_data));

  regfile_dump_reader #(.NUM_REGS(4), .SYNC_BYTE(8'hA5), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .rf_addr(b_addr), .rf_data(b_rf_data),
    .tx_valid(b_valid), .tx_ready(b_ready), .tx_data(b_data));

  int n_checks = 0;
  int n_fail   = 0;
  int end_cyc, done_cyc, n_done;
  logic end_valid;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_pattern();
    for (int i = 0; i < 32; i++) rf[i] = 32'h01020300 + 32'(i);
  endtask

  task automatic build_exp(input int nregs, input bit msb);
    logic [31:0] w;
    logic [7:0]  b, cs;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    for (int i = 0; i < nregs; i++) begin
      w = (i == 0) ? 32'h0 : rf[i];
      for (int k = 0; k < 4; k++) begin
        b = msb ? w[31 - 8*k -: 8] : w[8*k +: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  // Cycle c is the cycle whose handshake lands on the c-th edge after the start edge.
  task automatic run_frame(input int nregs, input bit msb, input bit bp,
                           input int abort_cyc, input int restart_cyc);
    bit         prev_stall, finished;
    logic [7:0] prev_data;
    int         p;
    got_q.delete();
    build_exp(nregs, msb);
    n_done = 0; done_cyc = -1; end_cyc = -1; end_valid = 1'bx;
    prev_stall = 1'b0; prev_data = 8'h00; finished = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clk);
      start    = (c == restart_cyc);
      abort    = (c == abort_cyc);
      tx_ready = bp ? ((((c - 1) % 4) == 0) || (((c - 1) % 4) == 3)) : 1'b1;
      #1;
      if (c == 1) check("busy_c1", 32'(o_busy), 32'd1);
      if (prev_stall) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_data", 32'(o_data), 32'(prev_data));
      end
      if (o_done) begin
        n_done++;
        done_cyc = c;
      end
      if (o_valid && tx_ready && !abort) begin
        p = got_q.size();
        if (p >= 1 && p <= 4*nregs) check("rf_addr", 32'(o_addr), 32'((p - 1) / 4));
        got_q.push_back(o_data);
      end
      prev_stall = o_valid && !tx_ready && !abort;
      prev_data  = o_data;
      if (c > 1 && !o_busy) begin
        end_cyc   = c;
        end_valid = o_valid;
        finished  = 1'b1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
    check("frame_terminated", 32'(finished), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] g;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
    check({tag, "_ndone"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1; dsel = 1'b0;
    set_pattern();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_data",  32'(a_data),  32'd0);
    check("rst_addr",  32'(a_addr),  32'd0);
    reset = 1'b1;

    // Ordering with hand-computed landmarks
    run_frame(32, 1'b1, 1'b0, -1, -1);
    check_frame("order");
    check("order_sync",   32'(got_q[0]),   32'hA5);
    check("order_x1",     {got_q[5], got_q[6], got_q[7], got_q[8]}, 32'h01020301);
    check("order_x31",    {got_q[125], got_q[126], got_q[127], got_q[128]}, 32'h0102031F);
    check("order_csum",   32'(got_q[129]), 32'h00);
    check("order_donecyc", 32'(done_cyc), 32'd162);
    check("order_busyoff", 32'(end_cyc),  32'd163);

    // Checksum corner cases
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFFFFFF;
    run_frame(32, 1'b1, 1'b0, -1, -1);
    check_frame("csum_ff");
    check("csum_ff_val", 32'(got_q[129]), 32'h00);
    rf[5] = 32'h00000001;
    run_frame(32, 1'b1, 1'b0, -1, -1);
    check("csum_x5_val", 32'(got_q[129]), 32'h01);

    // Backpressure 1,0,0,1
    set_pattern();
    run_frame(32, 1'b1, 1'b1, -1, -1);
    check_frame("bp");

    // LSB-first instance
    dsel = 1'b1;
    rf[1] = 32'hDEADBEEF;
    run_frame(4, 1'b0, 1'b0, -1, -1);
    check_frame("lsb");
    check("lsb_x1", {got_q[5], got_q[6], got_q[7], got_q[8]}, 32'hEFBEADDE);
    check("lsb_donecyc", 32'(done_cyc), 32'd22);
    dsel = 1'b0;

    // Abort during x10 byte 2 (cycle 55), then a clean restart
    set_pattern();
    run_frame(32, 1'b1, 1'b0, 55, -1);
    check("abort_endcyc", 32'(end_cyc), 32'd56);
    check("abort_valid",  32'(end_valid), 32'd0);
    check("abort_ndone",  32'(n_done), 32'd0);
    check("abort_len",    32'(got_q.size()), 32'd43);
    for (int i = 0; i < 43; i++) check($sformatf("abort_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    run_frame(32, 1'b1, 1'b0, -1, -1);
    check_frame("restart");

    // Start while busy must not disturb the frame
    run_frame(32, 1'b1, 1'b0, -1, 30);
    check_frame("busy_start");
    check("busy_start_donecyc", 32'(done_cyc), 32'd162);

    // Asynchronous reset in the middle of SEND (cycle 20 = x3 byte 2)
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    check("mid_valid_pre", 32'(a_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_busy",  32'(a_busy),  32'd0);
    check("mid_rst_valid", 32'(a_valid), 32'd0);
    check("mid_rst_data",  32'(a_data),  32'd0);
    check("mid_rst_addr",  32'(a_addr),  32'd0);
    check("mid_rst_done",  32'(a_done),  32'd0);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    check("post_rst_idle", 32'(a_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
